// File: rtl/step_controller.sv
// Run/step/halt scheduler: a programmable tick generator gated into a
// single-cycle CPU clock-enable according to user requests and the CPU halt flag.
module step_controller #(
  parameter int DIV_W       = 18,
  parameter int DEFAULT_DIV = 200000,
  parameter int CNT_W       = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             cpu_halted,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] divisor;
  logic             run_req_p1;
  logic             step_req_p1;
  logic             halt_req_p1;
  logic             tick_now;
  logic             run_rise;
  logic             step_rise;
  logic             halt_rise;

  // Modulo-2^CNT_W increment; the issued-enable count wraps instead of saturating.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // A load always wins over a tick that would otherwise fire on the same edge.
  assign tick_now  = !div_load && (tick_cnt == divisor);
  assign run_rise  = run_req  & ~run_req_p1;
  assign step_rise = step_req & ~step_req_p1;
  assign halt_rise = halt_req & ~halt_req_p1;

  // Tick generator: free-running counter with runtime-programmable period.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      tick_cnt <= '0;
      divisor  <= DIV_W'(DEFAULT_DIV);
    end else if (div_load) begin
      divisor  <= div_value;
      tick_cnt <= '0;
    end else if (tick_cnt == divisor) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  // Request edge detect; cleared by reset so a held request re-fires afterwards.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      run_req_p1  <= 1'b0;
      step_req_p1 <= 1'b0;
      halt_req_p1 <= 1'b0;
    end else begin
      run_req_p1  <= run_req;
      step_req_p1 <= step_req;
      halt_req_p1 <= halt_req;
    end
  end

  // Scheduler FSM with registered enable pulse and issued-enable counter.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= IDLE;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      cpu_en <= 1'b0;
      if (cpu_halted && state_q != HALTED) begin
        state_q <= HALTED;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (halt_rise) begin
              state_q <= IDLE;
            end else if (step_rise) begin
              state_q <= STEP_WAIT;
            end else if (run_rise) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (halt_rise) begin
              state_q <= IDLE;
            end else if (tick_now) begin
              cpu_en     <= 1'b1;
              step_count <= count_inc(step_count);
            end
          end
          STEP_WAIT: begin
            if (halt_rise) begin
              state_q <= IDLE;
            end else if (tick_now) begin
              state_q    <= IDLE;
              cpu_en     <= 1'b1;
              step_count <= count_inc(step_count);
            end
          end
          HALTED: begin
            state_q <= HALTED;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: run, step, halt, cpu_halted, divisor changes, counter wrap.
module tb_step_controller;

  localparam int DIV_W = 18;
  localparam int CNT_W = 16;

  logic             clock_in;
  logic             reset;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             cpu_halted;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] step_count;

  int vectors;
  int miscompares;

  step_controller #(.DIV_W(DIV_W), .DEFAULT_DIV(200000), .CNT_W(CNT_W)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .div_load  (div_load),
    .div_value (div_value),
    .run_req   (run_req),
    .step_req  (step_req),
    .halt_req  (halt_req),
    .cpu_halted(cpu_halted),
    .cpu_en    (cpu_en),
    .state     (state),
    .step_count(step_count)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic cyc();
    @(posedge clock_in);
    #1;
  endtask

  // Reset, then load a divisor so the tick counter starts from R=0.
  task automatic init(input logic [DIV_W-1:0] d);
    reset = 1'b1; div_load = 1'b0; run_req = 1'b0; step_req = 1'b0;
    halt_req = 1'b0; cpu_halted = 1'b0; div_value = '0;
    cyc();
    reset = 1'b0; div_load = 1'b1; div_value = d;
    cyc();
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    init(4);
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
    vectors++;
    if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_en got %0b exp 0", cpu_en); end
    vectors++;
    if (step_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", step_count); end
  endtask

  task automatic test_run();
    int pulses, first, last, bad_gap;
    init(4);
    run_req = 1'b1; cyc(); run_req = 1'b0;
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL run_state got %0d exp 1", state); end
    pulses = 0; first = -1; last = -1; bad_gap = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (cpu_en === 1'b1) begin
        if (first < 0) first = i;
        if (last >= 0 && i - last != 5) bad_gap++;
        last = i;
        pulses++;
      end
    end
    vectors++;
    if (first !== 3) begin miscompares++; $display("FAIL run_first_pulse got %0d exp 3", first); end
    vectors++;
    if (pulses !== 3) begin miscompares++; $display("FAIL run_pulses got %0d exp 3", pulses); end
    vectors++;
    if (bad_gap !== 0) begin miscompares++; $display("FAIL run_gap bad gaps %0d exp 0", bad_gap); end
    vectors++;
    if (step_count !== 16'd3) begin miscompares++; $display("FAIL run_count got %0d exp 3", step_count); end
  endtask

  task automatic test_step();
    int pulses, at;
    init(4);
    step_req = 1'b1; cyc(); step_req = 1'b0;
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL step_state got %0d exp 2", state); end
    pulses = 0; at = -1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cpu_en === 1'b1) begin pulses++; at = i; end
    end
    vectors++;
    if (pulses !== 1 || at !== 3) begin
      miscompares++; $display("FAIL step1_pulse got %0d pulses at %0d exp 1 at 3", pulses, at);
    end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL step1_idle got %0d exp 0", state); end
    vectors++;
    if (step_count !== 16'd1) begin miscompares++; $display("FAIL step1_count got %0d exp 1", step_count); end
    step_req = 1'b1; cyc(); step_req = 1'b0;
    pulses = 0; at = -1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cpu_en === 1'b1) begin pulses++; at = i; end
    end
    vectors++;
    if (pulses !== 1 || at !== 1) begin
      miscompares++; $display("FAIL step2_pulse got %0d pulses at %0d exp 1 at 1", pulses, at);
    end
    vectors++;
    if (step_count !== 16'd2) begin miscompares++; $display("FAIL step2_count got %0d exp 2", step_count); end
  endtask

  task automatic test_step_cancel();
    int pulses;
    init(4);
    step_req = 1'b1; cyc(); step_req = 1'b0;
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL cancel_state got %0d exp 0", state); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (cpu_en === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || step_count !== 16'd0) begin
      miscompares++; $display("FAIL cancel_no_en got %0d pulses count %0d exp 0/0", pulses, step_count);
    end
  endtask

  task automatic test_priority();
    init(4);
    run_req = 1'b1; step_req = 1'b1; halt_req = 1'b1; cyc();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL prio_halt got %0d exp 0", state); end
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; cyc();
    run_req = 1'b1; step_req = 1'b1; cyc();
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL prio_step got %0d exp 2", state); end
    run_req = 1'b0; step_req = 1'b0; cyc();
    run_req = 1'b1; cyc(); run_req = 1'b0;
    vectors++;
    if (state !== 2'd2 && !(state === 2'd0 && cpu_en === 1'b1)) begin
      miscompares++; $display("FAIL prio_run_ignored got %0d exp 2", state);
    end
  endtask

  task automatic test_halt_on_tick();
    int pulses;
    init(4);
    run_req = 1'b1; cyc(); run_req = 1'b0;
    cyc(); cyc(); cyc();
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    vectors++;
    if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL halt_tick_en got %0b exp 0", cpu_en); end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL halt_tick_state got %0d exp 0", state); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cpu_en === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || step_count !== 16'd0) begin
      miscompares++; $display("FAIL halt_tick_after got %0d pulses count %0d exp 0/0", pulses, step_count);
    end
  endtask

  task automatic test_cpu_halted();
    int pulses, not_halted;
    init(4);
    run_req = 1'b1; cyc(); run_req = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    cpu_halted = 1'b1; cyc();
    vectors++;
    if (state !== 2'd3 || cpu_en !== 1'b0) begin
      miscompares++; $display("FAIL cpuhalt_enter got state %0d en %0b exp 3/0", state, cpu_en);
    end
    vectors++;
    if (step_count !== 16'd1) begin miscompares++; $display("FAIL cpuhalt_count got %0d exp 1", step_count); end
    cpu_halted = 1'b0;
    pulses = 0; not_halted = 0;
    for (int i = 0; i < 12; i++) begin
      run_req  = (i % 4) == 1;
      step_req = (i % 4) == 3;
      cyc();
      if (cpu_en === 1'b1) pulses++;
      if (state !== 2'd3) not_halted++;
    end
    run_req = 1'b0; step_req = 1'b0;
    vectors++;
    if (pulses !== 0 || not_halted !== 0) begin
      miscompares++; $display("FAIL cpuhalt_sticky got %0d pulses %0d non-halted cycles exp 0/0", pulses, not_halted);
    end
    reset = 1'b1; cyc(); reset = 1'b0;
    vectors++;
    if (state !== 2'd0 || step_count !== 16'd0 || cpu_en !== 1'b0) begin
      miscompares++; $display("FAIL cpuhalt_reset got state %0d count %0d en %0b exp 0/0/0", state, step_count, cpu_en);
    end
  endtask

  task automatic test_reset_abort();
    init(4);
    step_req = 1'b1; cyc(); step_req = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b1; cyc();
    vectors++;
    if (cpu_en !== 1'b0 || state !== 2'd0) begin
      miscompares++; $display("FAIL abort_step got en %0b state %0d exp 0/0", cpu_en, state);
    end
    run_req = 1'b1; cyc();
    reset = 1'b0; cyc();
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL held_run_after_reset got %0d exp 1", state); end
    run_req = 1'b0;
  endtask

  task automatic test_div0_reload();
    int lows, at;
    init(0);
    run_req = 1'b1; cyc(); run_req = 1'b0;
    vectors++;
    if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL div0_entry_en got %0b exp 0", cpu_en); end
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (cpu_en !== 1'b1) lows++;
    end
    vectors++;
    if (lows !== 0 || step_count !== 16'd5) begin
      miscompares++; $display("FAIL div0_every_cycle got %0d gaps count %0d exp 0/5", lows, step_count);
    end
    div_load = 1'b1; div_value = 2; cyc(); div_load = 1'b0;
    vectors++;
    if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL load_cycle_en got %0b exp 0", cpu_en); end
    at = -1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (cpu_en === 1'b1 && at < 0) at = i;
    end
    vectors++;
    if (at !== 2) begin miscompares++; $display("FAIL reload_next_pulse got %0d exp 2", at); end
  endtask

  task automatic test_wrap();
    int lows;
    init(0);
    run_req = 1'b1; cyc(); run_req = 1'b0;
    lows = 0;
    for (int i = 0; i < 65535; i++) begin
      cyc();
      if (cpu_en !== 1'b1) lows++;
    end
    vectors++;
    if (step_count !== 16'hFFFF || lows !== 0) begin
      miscompares++; $display("FAIL wrap_preload got %0h gaps %0d exp ffff/0", step_count, lows);
    end
    cyc();
    vectors++;
    if (step_count !== 16'h0000 || cpu_en !== 1'b1) begin
      miscompares++; $display("FAIL wrap_rollover got %0h en %0b exp 0/1", step_count, cpu_en);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_run();
    test_step();
    test_step_cancel();
    test_priority();
    test_halt_on_tick();
    test_cpu_halted();
    test_reset_abort();
    test_div0_reload();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Run/step/halt scheduler for the pipelined MIPS CPU on the board.
- Owns a programmable tick generator: a free-running counter that emits one-cycle pulses, with the period configurable at runtime.
- Gates those ticks into a single-cycle CPU enable according to user run/step/halt requests and the CPU's own halted flag.
- Sits between the board buttons/switches and the CPU's global clock-enable input.

Parameters:
- DIV_W, 18, width of the tick counter and divisor register.
- DEFAULT_DIV, 200000, divisor loaded at reset; tick period = divisor+1 cycles.
- CNT_W, 16, width of the issued-enable counter.

Ports:
- clock_in  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- div_load  input  1  load div_value into divisor register this cycle.
- div_value  input  DIV_W  new divisor.
- run_req  input  1  level; its rising edge requests continuous run.
- step_req  input  1  level; its rising edge requests a single step.
- halt_req  input  1  level; its rising edge requests stop.
- cpu_halted  input  1  level from CPU (e.g. halt instruction); forces terminal halt.
- cpu_en  output  1  registered one-cycle CPU enable pulse.
- state  output  2  current FSM state encoding.
- step_count  output  CNT_W  number of cpu_en pulses issued.

Behaviour:
- Reset (synchronous, clock_in edge with reset=1):
  - counter R=0, divisor=DEFAULT_DIV, state=IDLE, cpu_en=0, step_count=0.
  - Request edge-detect registers are cleared to 0, so a request held high through reset produces a rising edge in the first cycle after reset.
  - Reset overrides every other input.
- Tick generator:
  - Each edge: if div_load, divisor<=div_value and R<=0. Else if R==divisor, R<=0 and tick_now=1. Else R<=R+1.
  - divisor=0 gives a tick every cycle.
  - No tick is produced in a div_load cycle.
- Edge detect: each request is registered once per cycle; rise = req & ~req_q.
- FSM states: IDLE=0, RUN=1, STEP_WAIT=2, HALTED=3.
  - Any state except HALTED, cpu_halted=1 -> HALTED; highest priority.
  - IDLE:
    - halt rise: stay IDLE.
    - step rise: -> STEP_WAIT.
    - run rise: -> RUN.
    - Priority halt > step > run.
  - RUN:
    - halt rise -> IDLE.
    - step and run rises are ignored.
  - STEP_WAIT:
    - halt rise -> IDLE, step cancelled, no cpu_en issued.
    - On tick_now -> IDLE, with one cpu_en issued.
    - run and step rises are ignored.
  - HALTED: left only by reset.
- cpu_en is registered. It is 1 in the cycle after an edge where tick_now=1 and, in the same edge, state was RUN, or state was STEP_WAIT with no halt rise. It is never asserted when cpu_halted=1 at that edge.
- step_count increments on every edge that sets cpu_en=1; it wraps modulo 2^CNT_W without saturating.
- Simultaneous events:
  - RUN state with halt rise on a tick edge: transition to IDLE and no cpu_en; halt wins.
  - div_load on the edge a tick would fire: the load wins and no cpu_en is issued.
- Reset mid-step or mid-run aborts immediately; cpu_en is 0 in the following cycle.
- Latency:
  - Request rise to FSM state change: 1 edge after the rise is first seen.
  - STEP_WAIT to cpu_en: up to divisor+1 cycles.

Test Plan:
- Reset, div_load with div_value=4, pulse run_req -> state=RUN; cpu_en is a single-cycle pulse every 5 cycles; step_count=3 after 3 pulses.
- In IDLE with divisor 4, single step_req rise -> exactly one cpu_en within 5 cycles, then state=IDLE and step_count=1; a second rise gives step_count=2.
- RUN, then assert halt_req on the edge where R==4 -> no cpu_en that period, state=IDLE, step_count unchanged.
- RUN, then cpu_halted=1 -> state=3 next cycle and cpu_en stays 0; run_req/step_req rises leave state=3 until reset, after which state=0 and step_count=0.
- Divisor 0 with run -> cpu_en high every cycle. Then div_load with div_value=2 mid-run -> no pulse in the load cycle, next pulse 3 cycles later.
- Preload 16 bits all ones: force step_count=0xFFFF by running 65535 ticks at divisor 0, one more -> step_count=0x0000, no stall.
